// File: rtl/transform_decoder_if.sv
// Block-level handshake bus of the 4x4 inverse transform decoder: coefficient input side
// and residual output side, each with its own valid/ready pair.
interface transform_decoder_if #(
    parameter int BIT_LENGTH = 15
);
    logic                       in_valid;
    logic                       in_ready;
    logic [15:0][BIT_LENGTH:0]  coeffs;
    logic                       out_valid;
    logic                       out_ready;
    logic [15:0][BIT_LENGTH:0]  residuals;

    // Producer/consumer side (entropy decoder upstream, reconstruction adder downstream).
    modport master (
        output in_valid, coeffs, out_ready,
        input  in_ready, out_valid, residuals
    );

    modport slave (
        input  in_valid, coeffs, out_ready,
        output in_ready, out_valid, residuals
    );
endinterface

// File: rtl/transform_decoder.sv
// 4x4 H.264-style inverse quantizer and inverse integer transform: one block in, dequant,
// four row butterflies, four column butterflies with rounding/saturation, one block out.
module transform_decoder #(
    parameter int BIT_LENGTH = 15,
    parameter int QP_BY_6    = 4,
    parameter int QP_MOD_6   = 4,
    parameter int INT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    transform_decoder_if.slave bus
);

    localparam int W = BIT_LENGTH + 1;

    typedef logic signed [INT_W-1:0] word_t;
    typedef logic signed [W-1:0]     res_t;

    typedef enum logic [2:0] {
        IDLE,
        DEQ,
        ROW,
        COL,
        OUT
    } state_t;

    localparam word_t SAT_MAX = word_t'((64'sd1 <<< BIT_LENGTH) - 64'sd1);
    localparam word_t SAT_MIN = word_t'(-(64'sd1 <<< BIT_LENGTH));
    localparam word_t ROUND   = word_t'(32);

    state_t             state, state_next;
    logic [1:0]         cnt, cnt_next;
    word_t              w [16];
    logic [15:0][W-1:0] res;

    word_t              d  [4];
    word_t              bf [4];

    // Level-scale factor for raster position idx: class 0 both even, 1 both odd, 2 mixed.
    function automatic word_t level_scale(input int idx);
        int cls;
        int v;
        logic row_odd, col_odd;
        row_odd = idx[2];
        col_odd = idx[0];
        if (!row_odd && !col_odd)    cls = 0;
        else if (row_odd && col_odd) cls = 1;
        else                         cls = 2;
        v = 0;
        case (QP_MOD_6)
            0: v = (cls == 0) ? 10 : (cls == 1) ? 16 : 13;
            1: v = (cls == 0) ? 11 : (cls == 1) ? 18 : 14;
            2: v = (cls == 0) ? 13 : (cls == 1) ? 20 : 16;
            3: v = (cls == 0) ? 14 : (cls == 1) ? 23 : 18;
            4: v = (cls == 0) ? 16 : (cls == 1) ? 25 : 20;
            5: v = (cls == 0) ? 18 : (cls == 1) ? 29 : 23;
            default: v = 0;
        endcase
        return word_t'(v);
    endfunction

    // Round by 1/64 and clamp into the signed residual range.
    function automatic res_t round_sat(input word_t x);
        word_t y;
        y = (x + ROUND) >>> 6;
        if (y > SAT_MAX)      return res_t'(SAT_MAX);
        else if (y < SAT_MIN) return res_t'(SAT_MIN);
        else                  return res_t'(y);
    endfunction

    assign bus.in_ready  = enable && (state == IDLE);
    assign bus.out_valid = (state == OUT);
    assign bus.residuals = res;

    // One shared butterfly: ROW reads w[cnt][0..3], COL reads w[0..3][cnt].
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            d[j] = (state == COL) ? w[{2'(j), cnt}] : w[{cnt, 2'(j)}];
        end
        bf[0] = (d[0] + d[2]) + (d[1] + (d[3] >>> 1));
        bf[1] = (d[0] - d[2]) + ((d[1] >>> 1) - d[3]);
        bf[2] = (d[0] - d[2]) - ((d[1] >>> 1) - d[3]);
        bf[3] = (d[0] + d[2]) - (d[1] + (d[3] >>> 1));
    end

    // NOTE: every signal assigned in this block gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: if (bus.in_valid) state_next = DEQ;
            DEQ: begin
                state_next = ROW;
                cnt_next   = 2'd0;
            end
            ROW: begin
                cnt_next = cnt + 2'd1;
                if (cnt == 2'd3) state_next = COL;
            end
            COL: begin
                cnt_next = cnt + 2'd1;
                if (cnt == 2'd3) state_next = OUT;
            end
            OUT: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 2'd0;
            res   <= '0;
            // NOTE: the coefficient buffer is plain flops and is cleared with everything
            // else, so a block discarded by reset leaves nothing behind.
            for (int i = 0; i < 16; i++) w[i] <= '0;
        end else if (enable) begin
            state <= state_next;
            cnt   <= cnt_next;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < 16; i++) w[i] <= word_t'($signed(bus.coeffs[i]));
                    end
                end
                DEQ: begin
                    for (int i = 0; i < 16; i++) w[i] <= (w[i] * level_scale(i)) <<< QP_BY_6;
                end
                ROW: begin
                    for (int j = 0; j < 4; j++) w[{cnt, 2'(j)}] <= bf[j];
                end
                COL: begin
                    for (int j = 0; j < 4; j++) res[{2'(j), cnt}] <= round_sat(bf[j]);
                end
                default: ;
            endcase
        end
    end

endmodule
